// File: rtl/hdmi_mode_ctrl.sv
// rtl/hdmi_mode_ctrl.sv - run/mode sequencer for the HDMI timing generator
module hdmi_mode_ctrl #(
  parameter int GUARD_CYCLES  = 16,
  parameter int DRAIN_TIMEOUT = 4950000,
  parameter int DEFAULT_MODE  = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        mode_valid_i,
  input  logic [1:0]  mode_id_i,
  output logic        mode_ready_o,
  input  logic        frame_start_i,
  output logic        tg_en_o,
  output logic        tg_rst_o,
  output logic [11:0] h_active_o,
  output logic [11:0] h_sync_o,
  output logic [11:0] h_total_o,
  output logic [11:0] v_active_o,
  output logic [11:0] v_sync_o,
  output logic [11:0] v_total_o,
  output logic [1:0]  cur_mode_o,
  output logic        busy_o,
  output logic        timeout_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_QUIET = 3'd4
  } state_t;

  typedef struct packed {
    logic [11:0] h_active;
    logic [11:0] h_sync;
    logic [11:0] h_total;
    logic [11:0] v_active;
    logic [11:0] v_sync;
    logic [11:0] v_total;
  } timing_t;

  localparam int WD_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam int GD_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(DRAIN_TIMEOUT - 1);
  localparam logic [GD_W-1:0] GD_LAST = GD_W'(GUARD_CYCLES - 1);

  // Timing table for the four supported video modes
  function automatic timing_t mode_rom(input logic [1:0] m);
    timing_t t;
    case (m)
      2'd0:    t = '{12'd640,  12'd96, 12'd800,  12'd480,  12'd2, 12'd525};
      2'd1:    t = '{12'd1280, 12'd40, 12'd1650, 12'd720,  12'd5, 12'd750};
      2'd2:    t = '{12'd1920, 12'd44, 12'd2200, 12'd1080, 12'd5, 12'd1125};
      default: t = '{12'd720,  12'd62, 12'd858,  12'd480,  12'd6, 12'd525};
    endcase
    return t;
  endfunction

  state_t          state;
  state_t          next_state;
  timing_t         timing;
  logic [1:0]      cur_mode;
  logic            pend_valid;
  logic [1:0]      pend_mode;
  logic [WD_W-1:0] wd_cnt;
  logic [GD_W-1:0] gd_cnt;
  logic            ready;
  logic            timeout;
  logic            accept;
  logic            wd_fire;
  logic            guard_done;

  assign accept     = mode_valid_i & ready;
  assign wd_fire    = (state == S_DRAIN) && !frame_start_i && (wd_cnt == WD_LAST);
  assign guard_done = (state == S_QUIET) && (gd_cnt == GD_LAST);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (en_i) next_state = S_LOAD;
      S_LOAD:  next_state = en_i ? S_RUN : S_IDLE;
      S_RUN:   if (accept || !en_i) next_state = S_DRAIN;
      S_DRAIN: if (frame_start_i || wd_fire) next_state = S_QUIET;
      S_QUIET: if (guard_done) next_state = (pend_valid || en_i) ? S_LOAD : S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    tg_en_o  = 1'b0;
    tg_rst_o = 1'b0;
    busy_o   = 1'b0;
    case (state)
      S_LOAD:  begin tg_rst_o = 1'b1; busy_o = 1'b1; end
      S_RUN:   tg_en_o = 1'b1;
      S_DRAIN: begin tg_en_o = 1'b1; busy_o = 1'b1; end
      S_QUIET: busy_o = 1'b1;
      default: ;
    endcase
  end

  // Counters, pending request, applied mode and sticky watchdog flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ready      <= 1'b0;
      timeout    <= 1'b0;
      wd_cnt     <= '0;
      gd_cnt     <= '0;
      pend_valid <= 1'b0;
      pend_mode  <= '0;
      cur_mode   <= 2'(DEFAULT_MODE);
      timing     <= mode_rom(2'(DEFAULT_MODE));
    end else begin
      ready  <= (next_state == S_IDLE) || (next_state == S_RUN);
      wd_cnt <= (state == S_DRAIN) ? wd_cnt + WD_W'(1) : '0;
      gd_cnt <= (state == S_QUIET) ? gd_cnt + GD_W'(1) : '0;
      if (wd_fire) timeout <= 1'b1;
      // Idle requests go straight to the outputs; running ones wait for LOAD
      if (state == S_IDLE && accept) begin
        cur_mode <= mode_id_i;
        timing   <= mode_rom(mode_id_i);
      end
      if (state == S_RUN && accept) begin
        pend_valid <= 1'b1;
        pend_mode  <= mode_id_i;
      end
      if (state == S_LOAD) begin
        if (pend_valid) begin
          cur_mode <= pend_mode;
          timing   <= mode_rom(pend_mode);
        end
        pend_valid <= 1'b0;
      end
    end
  end

  assign mode_ready_o = ready;
  assign timeout_o    = timeout;
  assign cur_mode_o   = cur_mode;
  assign h_active_o   = timing.h_active;
  assign h_sync_o     = timing.h_sync;
  assign h_total_o    = timing.h_total;
  assign v_active_o   = timing.v_active;
  assign v_sync_o     = timing.v_sync;
  assign v_total_o    = timing.v_total;

endmodule

// File: tb/tb_hdmi_mode_ctrl.sv
// tb/tb_hdmi_mode_ctrl.sv - directed self-checking bench for hdmi_mode_ctrl
module tb_hdmi_mode_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        mode_valid;
  logic [1:0]  mode_id;
  logic        mode_ready;
  logic        frame_start;
  logic        tg_en;
  logic        tg_rst;
  logic [11:0] h_active, h_sync, h_total, v_active, v_sync, v_total;
  logic [1:0]  cur_mode;
  logic        busy;
  logic        timeout;

  int checks = 0;
  int failures = 0;
  int cnt;
  int bad;

  hdmi_mode_ctrl #(.GUARD_CYCLES(16), .DRAIN_TIMEOUT(100), .DEFAULT_MODE(2)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_valid_i(mode_valid), .mode_id_i(mode_id),
    .mode_ready_o(mode_ready), .frame_start_i(frame_start), .tg_en_o(tg_en), .tg_rst_o(tg_rst),
    .h_active_o(h_active), .h_sync_o(h_sync), .h_total_o(h_total),
    .v_active_o(v_active), .v_sync_o(v_sync), .v_total_o(v_total),
    .cur_mode_o(cur_mode), .busy_o(busy), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_tg_en"}, tg_en, 0);
    check({tag, "_tg_rst"}, tg_rst, 0);
    check({tag, "_ready"}, mode_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_cur_mode"}, cur_mode, 2);
    check({tag, "_h"}, {h_active, h_total}, {12'd1920, 12'd2200});
    check({tag, "_v"}, {v_active, v_total}, {12'd1080, 12'd1125});
    check({tag, "_sync"}, {h_sync, v_sync}, {12'd44, 12'd5});
  endtask

  // Idle -> LOAD -> RUN with no pending request
  task automatic start_run(input string tag);
    en = 1'b1;
    tick();
    check({tag, "_load_rst"}, tg_rst, 1);
    tick();
    check({tag, "_run_en"}, tg_en, 1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode_valid = 1'b0; mode_id = 2'd0; frame_start = 1'b0;
    tick(2);
    check_reset_state("reset");
    rst = 1'b0;
    tick();
    check("idle_ready", mode_ready, 1);

    // Test 1: start from IDLE
    en = 1'b1;
    tick();
    check("t1_load_rst", tg_rst, 1);
    check("t1_load_en", tg_en, 0);
    check("t1_load_busy", busy, 1);
    check("t1_load_ready", mode_ready, 0);
    check("t1_load_tot", {h_total, v_total}, {12'd2200, 12'd1125});
    tick();
    check("t1_run_en", tg_en, 1);
    check("t1_run_rst", tg_rst, 0);
    check("t1_run_busy", busy, 0);
    check("t1_run_ready", mode_ready, 1);

    // Test 2: mode change in RUN applied after frame boundary and guard
    mode_valid = 1'b1; mode_id = 2'd1;
    tick();
    mode_valid = 1'b0;
    check("t2_drain_ready", mode_ready, 0);
    check("t2_drain_busy", busy, 1);
    check("t2_drain_mode", cur_mode, 2);
    bad = 0;
    for (int i = 0; i < 49; i++) begin
      tick();
      if (mode_ready !== 1'b0 || tg_en !== 1'b1) bad++;
    end
    check("t2_drain_hold", bad, 0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    cnt = 0;
    bad = 0;
    while (tg_en === 1'b0 && tg_rst === 1'b0 && cnt < 40) begin
      if (mode_ready !== 1'b0) bad++;
      cnt++;
      tick();
    end
    check("t2_quiet_len", cnt, 16);
    check("t2_quiet_ready", bad, 0);
    check("t2_load_rst", tg_rst, 1);
    check("t2_load_ready", mode_ready, 0);
    tick();
    check("t2_new_tot", {h_total, v_total}, {12'd1650, 12'd750});
    check("t2_new_act", {h_active, v_active}, {12'd1280, 12'd720});
    check("t2_cur_mode", cur_mode, 1);
    check("t2_run_en", tg_en, 1);
    check("t2_run_ready", mode_ready, 1);

    // Test 4: stop and mode-3 request together
    en = 1'b0; mode_valid = 1'b1; mode_id = 2'd3;
    tick();
    mode_valid = 1'b0;
    check("t4_drain_en", tg_en, 1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("t4_quiet_en", tg_en, 0);
    tick(16);
    check("t4_load_rst", tg_rst, 1);
    tick();
    check("t4_idle_tot", {h_total, v_total}, {12'd858, 12'd525});
    check("t4_idle_sync", {h_sync, v_sync}, {12'd62, 12'd6});
    check("t4_cur_mode", cur_mode, 3);
    check("t4_idle_en", tg_en, 0);
    check("t4_idle_busy", busy, 0);
    check("t4_idle_ready", mode_ready, 1);

    // Test 3: request while idle is applied on the accept edge
    mode_valid = 1'b1; mode_id = 2'd0;
    tick();
    mode_valid = 1'b0;
    check("t3_act", {h_active, v_total}, {12'd640, 12'd525});
    check("t3_cur_mode", cur_mode, 0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (tg_rst !== 1'b0 || tg_en !== 1'b0) bad++;
      tick();
    end
    check("t3_no_run", bad, 0);

    // Boundary: frame_start on the last permitted DRAIN cycle avoids timeout
    start_run("t5a");
    check("t5a_tot", h_total, 800);
    en = 1'b0;
    tick();
    tick(99);
    check("t5a_last_drain_en", tg_en, 1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("t5a_quiet_en", tg_en, 0);
    check("t5a_no_timeout", timeout, 0);
    tick(16);
    check("t5a_idle_busy", busy, 0);

    // Test 5: watchdog fires after 100 DRAIN cycles
    start_run("t5");
    en = 1'b0;
    tick();
    tick(98);
    check("t5_drain99_to", timeout, 0);
    tick();
    check("t5_drain100_en", tg_en, 1);
    check("t5_drain100_to", timeout, 0);
    tick();
    check("t5_fired", timeout, 1);
    check("t5_fired_en", tg_en, 0);
    tick(16);
    check("t5_idle_busy", busy, 0);
    check("t5_idle_rst", tg_rst, 0);
    start_run("t5b");
    check("t5_sticky", timeout, 1);

    // Test 6: reset during QUIET discards the pending request
    mode_valid = 1'b1; mode_id = 2'd0;
    tick();
    mode_valid = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick(5);
    check("t6_in_quiet", {busy, tg_en}, 2'b10);
    rst = 1'b1;
    tick();
    check_reset_state("t6");
    rst = 1'b0; en = 1'b1;
    tick();
    check("t6_load_rst", tg_rst, 1);
    tick();
    check("t6_run_mode", cur_mode, 2);
    check("t6_run_tot", h_total, 2200);
    check("t6_run_en", tg_en, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
